// File: rtl/wino_pkg.sv
// wino_pkg: shared definitions for the Winograd operand sequencer.
//   - 3-bit state encodings and the FSM state type
//   - byte width, result byte count, default operand word count
//   - res_byte(): selects result byte idx, most significant byte first
package wino_pkg;

  localparam int WINO_BYTE_W        = 8;
  localparam int WINO_RES_BYTES     = 4;
  localparam int WINO_NUM_WORDS_DEF = 11;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD_HI  = 3'd1;
  localparam logic [2:0] ST_LOAD_LO  = 3'd2;
  localparam logic [2:0] ST_SEND     = 3'd3;
  localparam logic [2:0] ST_WAIT_RES = 3'd4;
  localparam logic [2:0] ST_UNPACK   = 3'd5;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    LOAD_HI  = ST_LOAD_HI,
    LOAD_LO  = ST_LOAD_LO,
    SEND     = ST_SEND,
    WAIT_RES = ST_WAIT_RES,
    UNPACK   = ST_UNPACK
  } wino_state_t;

  // Byte 0 is res[31:24], byte 3 is res[7:0].
  function automatic logic [WINO_BYTE_W-1:0] res_byte(input logic [31:0] res,
                                                     input logic [1:0]  idx);
    logic [WINO_BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = res[31:24];
      2'd1:    b = res[23:16];
      2'd2:    b = res[15:8];
      default: b = res[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/wino_result_serializer.sv
// wino_result_serializer: holds the captured 32-bit Winograd result and
// streams it out as four bytes, most significant byte first.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   capture         one-cycle pulse: load res_word, restart at byte 0
//   res_word        packed result word
//   unpack          parent FSM is in UNPACK (bytes may be offered)
//   out_ready       downstream accepts the byte
//   out_valid       byte valid (same as unpack)
//   out_byte        current result byte
//   out_last        high with the 4th byte
//   fin             combinational: 4th byte accepted this cycle
//   done            registered one-cycle pulse following fin
module wino_result_serializer
  import wino_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   capture,
  input  logic [31:0]            res_word,
  input  logic                   unpack,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [WINO_BYTE_W-1:0] out_byte,
  output logic                   out_last,
  output logic                   fin,
  output logic                   done
);

  localparam logic [1:0] LAST_IDX = 2'(WINO_RES_BYTES - 1);

  logic [31:0] res_q;
  logic [1:0]  idx_q;

  assign out_valid = unpack;
  assign out_last  = unpack && (idx_q == LAST_IDX);
  assign fin       = out_last && out_ready;
  // Byte is a pure function of registered state, so it cannot move while stalled.
  assign out_byte  = res_byte(res_q, idx_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      res_q <= '0;
      idx_q <= '0;
      done  <= 1'b0;
    end else begin
      done <= fin;
      if (capture) begin
        res_q <= res_word;
        idx_q <= '0;
      end else if (out_valid && out_ready && !out_last) begin
        // idx parks on the last byte so out_byte keeps showing it after the tile.
        idx_q <= idx_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/wino_operand_sequencer.sv
// wino_operand_sequencer: packs an input byte stream into operand words
// {16'd0, hi, lo}, issues NUM_WORDS of them to the ALU operand port, waits
// for the packed 32-bit result and serialises it back out as four bytes.
// Optional feature macro: WINO_TIMEOUT_EN adds a result-wait watchdog and
// the timeout port.
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   start / busy                   begin tile (sampled in IDLE) / not IDLE
//   in_valid, in_ready, in_byte    operand byte input
//   op_valid, op_ready, op_word,
//   op_last                        operand word output to the ALU
//   res_valid, res_word            result word input (one-cycle pulse)
//   out_valid, out_ready, out_byte,
//   out_last                       result byte output
//   done                           pulse after the 4th byte is accepted
//   timeout                        (WINO_TIMEOUT_EN only) watchdog pulse
module wino_operand_sequencer
  import wino_pkg::*;
#(
  parameter int NUM_WORDS   = WINO_NUM_WORDS_DEF,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WINO_BYTE_W-1:0] in_byte,
  output logic                   op_valid,
  input  logic                   op_ready,
  output logic [31:0]            op_word,
  output logic                   op_last,
  input  logic                   res_valid,
  input  logic [31:0]            res_word,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WINO_BYTE_W-1:0] out_byte,
  output logic                   out_last,
  output logic                   done
`ifdef WINO_TIMEOUT_EN
  ,
  output logic                   timeout
`endif
);

  localparam logic [3:0] LAST_WORD = 4'(NUM_WORDS - 1);

  // Illegal configurations show up as this otherwise empty block in the
  // elaborated hierarchy.
  if (NUM_WORDS < 1 || NUM_WORDS > 15 || TIMEOUT_CYC < 1) begin : g_illegal_cfg
  end

  wino_state_t            state_q, state_d;
  logic [WINO_BYTE_W-1:0] hi_q, lo_q;
  logic [3:0]             word_cnt_q;
  logic                   capture;
  logic                   unpack;
  logic                   ser_fin;

  assign busy     = (state_q != IDLE);
  assign in_ready = (state_q == LOAD_HI) || (state_q == LOAD_LO);
  assign op_valid = (state_q == SEND);
  assign op_last  = (state_q == SEND) && (word_cnt_q == LAST_WORD);
  // Packing registers only change in LOAD_*, so op_word is frozen through SEND.
  assign op_word  = {16'd0, hi_q, lo_q};
  assign capture  = (state_q == WAIT_RES) && res_valid;
  assign unpack   = (state_q == UNPACK);

`ifdef WINO_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            to_hit;

  assign to_hit = (state_q == WAIT_RES) && !res_valid &&
                  (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  // Counter is held at zero outside WAIT_RES, which clears it on entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt_q <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= to_hit;
      if (state_q != WAIT_RES) begin
        to_cnt_q <= '0;
      end else if (!res_valid) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = LOAD_HI;
      LOAD_HI:  if (in_valid) state_d = LOAD_LO;
      LOAD_LO:  if (in_valid) state_d = SEND;
      SEND: begin
        if (op_ready) begin
          state_d = (word_cnt_q == LAST_WORD) ? WAIT_RES : LOAD_HI;
        end
      end
      WAIT_RES: begin
        if (res_valid) begin
          state_d = UNPACK;
        end
`ifdef WINO_TIMEOUT_EN
        else if (to_hit) begin
          state_d = IDLE;
        end
`endif
      end
      UNPACK:   if (ser_fin) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE:    word_cnt_q <= '0;
        LOAD_HI: if (in_valid) hi_q <= in_byte;
        LOAD_LO: if (in_valid) lo_q <= in_byte;
        // Peaks at NUM_WORDS (<= 15), so the 4-bit counter never wraps.
        SEND:    if (op_ready) word_cnt_q <= word_cnt_q + 4'd1;
        default: ;
      endcase
    end
  end

  wino_result_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .capture   (capture),
    .res_word  (res_word),
    .unpack    (unpack),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_byte  (out_byte),
    .out_last  (out_last),
    .fin       (ser_fin),
    .done      (done)
  );

endmodule

// File: tb/tb_wino_operand_sequencer.sv
module tb_wino_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        op_ready = 1'b0;
  logic        res_valid = 1'b0;
  logic [31:0] res_word = 32'h0;
  logic        out_ready = 1'b0;
  logic        busy, in_ready, op_valid, op_last, out_valid, out_last, done;
  logic [31:0] op_word;
  logic [7:0]  out_byte;
`ifdef WINO_TIMEOUT_EN
  logic        timeout;
`endif

  always #5 clk = ~clk;

  wino_operand_sequencer #(.NUM_WORDS(11), .TIMEOUT_CYC(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_byte   (in_byte),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_word   (op_word),
    .op_last   (op_last),
    .res_valid (res_valid),
    .res_word  (res_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_last  (out_last),
    .done      (done)
`ifdef WINO_TIMEOUT_EN
    ,
    .timeout   (timeout)
`endif
  );

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] exp_word;
    logic        exp_last;
  } vec_t;

  vec_t vtab[11];
  vec_t vtab_b[11];

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic start_tile();
    chk1("idle_before_start", busy, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk1("busy_after_start", busy, 1'b1);
  endtask

  task automatic send_words(input int tbl, input int nw, input int gap,
                            input bit rnd, input bit spur_res);
    vec_t v;
    bit   acc;
    logic r;
    for (int i = 0; i < nw; i++) begin
      v = (tbl == 0) ? vtab[i] : vtab_b[i];
      chk1("in_ready_load_hi", in_ready, 1'b1);
      chk1("op_valid_load_hi", op_valid, 1'b0);
      in_valid = 1'b1;
      in_byte  = v.hi;
      if (spur_res && i == 0) begin
        res_valid = 1'b1;
        res_word  = 32'hDEADBEEF;
      end
      @(negedge clk);
      res_valid = 1'b0;
      res_word  = 32'h0;
      if (gap > 0) begin
        in_valid = 1'b0;
        in_byte  = 8'hEE;
        repeat (gap) @(negedge clk);
        chk1("in_ready_gap", in_ready, 1'b1);
      end
      in_valid = 1'b1;
      in_byte  = v.lo;
      @(negedge clk);
      in_valid = 1'b0;
      in_byte  = 8'h00;
      chk1("in_ready_send", in_ready, 1'b0);
      chk1("op_valid_send", op_valid, 1'b1);
      chk32("op_word", op_word, {16'h0, v.exp_word});
      chk1("op_last", op_last, v.exp_last);
      acc = 1'b0;
      for (int c = 0; c < 64 && !acc; c++) begin
        r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        op_ready = r;
        @(negedge clk);
        if (r) acc = 1'b1;
        else begin
          chk32("op_word_stall", op_word, {16'h0, v.exp_word});
          chk1("op_valid_stall", op_valid, 1'b1);
        end
      end
      op_ready = 1'b0;
      if (!acc) chk1("op_handshake_bound", 1'b0, 1'b1);
    end
  endtask

  task automatic recv_result(input logic [31:0] rw, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3,
                             input bit rnd, input bit spur_start);
    logic [7:0] eb[4];
    int   d0;
    bit   acc;
    logic r;
    eb[0] = b0; eb[1] = b1; eb[2] = b2; eb[3] = b3;
    chk1("busy_wait_res", busy, 1'b1);
    chk1("op_valid_wait_res", op_valid, 1'b0);
    repeat (2) @(negedge clk);
    chk1("out_valid_wait_res", out_valid, 1'b0);
    d0 = done_cnt;
    res_valid = 1'b1;
    res_word  = rw;
    @(negedge clk);
    res_valid = 1'b0;
    res_word  = 32'h0;
    for (int j = 0; j < 4; j++) begin
      chk1("out_valid", out_valid, 1'b1);
      chk8("out_byte", out_byte, eb[j]);
      chk1("out_last", out_last, (j == 3));
      if (spur_start && j == 0) start = 1'b1;
      acc = 1'b0;
      for (int c = 0; c < 64 && !acc; c++) begin
        r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        out_ready = r;
        @(negedge clk);
        start = 1'b0;
        if (r) acc = 1'b1;
        else begin
          chk8("out_byte_stall", out_byte, eb[j]);
          chk1("out_valid_stall", out_valid, 1'b1);
        end
      end
      out_ready = 1'b0;
      if (!acc) chk1("out_handshake_bound", 1'b0, 1'b1);
    end
    chk1("done_pulse", done, 1'b1);
    chk1("busy_after_last", busy, 1'b0);
    chk1("out_valid_after_last", out_valid, 1'b0);
    @(negedge clk);
    chk1("done_clear", done, 1'b0);
    chk1("idle_after_tile", busy, 1'b0);
    chk32("done_count", done_cnt - d0, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_in_ready"}, in_ready, 1'b0);
    chk1({tag, "_op_valid"}, op_valid, 1'b0);
    chk1({tag, "_op_last"}, op_last, 1'b0);
    chk1({tag, "_out_valid"}, out_valid, 1'b0);
    chk1({tag, "_out_last"}, out_last, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk32({tag, "_op_word"}, op_word, 32'h0);
    chk8({tag, "_out_byte"}, out_byte, 8'h00);
`ifdef WINO_TIMEOUT_EN
    chk1({tag, "_timeout"}, timeout, 1'b0);
`endif
  endtask

  initial begin
    int d0;
    vtab[0]  = '{8'h01, 8'h02, 16'h0102, 1'b0};
    vtab[1]  = '{8'h03, 8'h04, 16'h0304, 1'b0};
    vtab[2]  = '{8'h05, 8'h06, 16'h0506, 1'b0};
    vtab[3]  = '{8'h07, 8'h08, 16'h0708, 1'b0};
    vtab[4]  = '{8'h09, 8'h0A, 16'h090A, 1'b0};
    vtab[5]  = '{8'h0B, 8'h0C, 16'h0B0C, 1'b0};
    vtab[6]  = '{8'h0D, 8'h0E, 16'h0D0E, 1'b0};
    vtab[7]  = '{8'h0F, 8'h10, 16'h0F10, 1'b0};
    vtab[8]  = '{8'h11, 8'h12, 16'h1112, 1'b0};
    vtab[9]  = '{8'h13, 8'h14, 16'h1314, 1'b0};
    vtab[10] = '{8'h15, 8'h16, 16'h1516, 1'b1};

    vtab_b[0]  = '{8'hFF, 8'h00, 16'hFF00, 1'b0};
    vtab_b[1]  = '{8'h00, 8'hFF, 16'h00FF, 1'b0};
    vtab_b[2]  = '{8'hA5, 8'h5A, 16'hA55A, 1'b0};
    vtab_b[3]  = '{8'h80, 8'h01, 16'h8001, 1'b0};
    vtab_b[4]  = '{8'h7F, 8'hFE, 16'h7FFE, 1'b0};
    vtab_b[5]  = '{8'hC3, 8'h3C, 16'hC33C, 1'b0};
    vtab_b[6]  = '{8'h12, 8'h34, 16'h1234, 1'b0};
    vtab_b[7]  = '{8'h56, 8'h78, 16'h5678, 1'b0};
    vtab_b[8]  = '{8'h9A, 8'hBC, 16'h9ABC, 1'b0};
    vtab_b[9]  = '{8'hDE, 8'hF0, 16'hDEF0, 1'b0};
    vtab_b[10] = '{8'hEE, 8'h11, 16'hEE11, 1'b1};

    // reset state
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // back-to-back tile, all readies high
    start_tile();
    send_words(0, 11, 0, 1'b0, 1'b0);
    recv_result(32'hA1B2C3D4, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 1'b0, 1'b0);
    chk32("op_word_hold", op_word, 32'h0000_1516);

    // random backpressure on both output ports
    @(negedge clk);
    start_tile();
    send_words(1, 11, 0, 1'b1, 1'b0);
    recv_result(32'h5A6B7C8D, 8'h5A, 8'h6B, 8'h7C, 8'h8D, 1'b1, 1'b0);

    // input gaps, spurious res_valid in LOAD_HI, start during UNPACK
    @(negedge clk);
    start_tile();
    send_words(0, 11, 5, 1'b0, 1'b1);
    recv_result(32'h11223344, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk1("start_in_unpack_ignored", busy, 1'b0);

    // reset after the 5th word, then a normal tile
    start_tile();
    send_words(1, 5, 0, 1'b0, 1'b0);
    d0 = done_cnt;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midreset");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk32("midreset_no_done", done_cnt - d0, 32'd0);
    start_tile();
    send_words(0, 11, 0, 1'b0, 1'b0);
    recv_result(32'hF00DCAFE, 8'hF0, 8'h0D, 8'hCA, 8'hFE, 1'b1, 1'b0);

`ifdef WINO_TIMEOUT_EN
    begin
      int cnt;
      @(negedge clk);
      start_tile();
      send_words(0, 11, 0, 1'b0, 1'b0);
      d0  = done_cnt;
      cnt = 0;
      while (timeout !== 1'b1 && cnt < 200) begin
        @(negedge clk);
        cnt++;
      end
      chk32("timeout_latency", cnt, 32'd64);
      chk1("timeout_idle", busy, 1'b0);
      @(negedge clk);
      chk1("timeout_clear", timeout, 1'b0);
      chk32("timeout_no_done", done_cnt - d0, 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got hang expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
